// File: rtl/imem_loader_pkg.sv
// Shared processor package: instruction-memory geometry defaults and the
// program-loader FSM state encoding.
package imem_loader_pkg;

  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Streams a header byte (word count) plus little-endian words into the
// external instruction memory, holding the core in reset until a load succeeds.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  loader_state_e     state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              accept;

  // Gating with rst keeps a reset cycle free of byte transfers and writes.
  assign byte_ready = !rst && ((state_q == ST_HDR) || (state_q == ST_DATA));
  assign mem_we     = !rst && (state_q == ST_WRITE);
  assign accept     = byte_valid && byte_ready;

  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_rst    = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_HDR;
          idx_d      = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
        end
      end

      ST_HDR: begin
        if (accept) begin
          n_d = byte_data;
          if (byte_data == 8'd0) begin
            state_d = ST_DONE;
          end else if (32'(byte_data) > DEPTH) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      // Earlier bytes slide down so byte k lands at bits [8k+7:8k].
      ST_DATA: begin
        if (accept) begin
          shift_d = {byte_data, shift_q[23:8]};
          if (byte_cnt_q == 2'd3) begin
            state_d    = ST_WRITE;
            byte_cnt_d = '0;
            waddr_d    = idx_q[ADDR_W-1:0];
            wdata_d    = {byte_data, shift_q};
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      // idx carries one spare bit so reaching DEPTH never wraps to zero.
      ST_WRITE: begin
        idx_d = idx_q + (ADDR_W + 1)'(1);
        if (32'(idx_q) + 32'd1 == 32'(n_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DATA;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives inputs 1 time unit after each rising
// edge and samples outputs on the falling edge.
module tb_imem_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int errors   = 0;
  int checks   = 0;
  int wr_count = 0;
  int wr_base;

  imem_loader #(.DEPTH(64), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) wr_count++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit accepted;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    accepted   = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) accepted = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    if (!accepted) check_output("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // Sends one word LSB-first and checks the WRITE cycle that must follow it.
  task automatic send_word(input logic [31:0] w, input int gap, input logic [ADDR_W-1:0] addr);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    @(negedge clk);
    check_output("write_we", 32'(mem_we), 32'd1);
    check_output("write_ready", 32'(byte_ready), 32'd0);
    check_output("write_addr", 32'(mem_waddr), 32'(addr));
    check_output("write_data", mem_wdata, w);
    tick();
  endtask

  function automatic logic [31:0] big_word(input int i);
    logic [7:0] a;
    logic [7:0] m;
    a = 8'(i);
    m = 8'(i * 3);
    return {a, 8'hA5, m, ~a};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check_output("rst_ready", 32'(byte_ready), 32'd0);
    check_output("rst_we", 32'(mem_we), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_output("rst_addr", 32'(mem_waddr), 32'd0);
    check_output("rst_data", mem_wdata, 32'd0);
    tick();
    rst = 1'b0;
    byte_valid = 1'b1;
    tick();
    @(negedge clk);
    check_output("idle_ready", 32'(byte_ready), 32'd0);
    tick();
    byte_valid = 1'b0;

    // Single-word load
    $display("[TB] single word load");
    wr_base = wr_count;
    pulse_start();
    @(negedge clk);
    check_output("hdr_ready", 32'(byte_ready), 32'd1);
    check_output("hdr_cpu_rst", 32'(cpu_rst), 32'd1);
    tick();
    send_byte(8'h01, 0);
    send_word(32'h0000_0013, 0, 6'd0);
    @(negedge clk);
    check_output("w1_done", 32'(done), 32'd1);
    check_output("w1_cpu_rst", 32'(cpu_rst), 32'd0);
    check_output("w1_we_low", 32'(mem_we), 32'd0);
    check_output("w1_hold_data", mem_wdata, 32'h0000_0013);
    tick();
    check_output("w1_wr_count", 32'(wr_count - wr_base), 32'd1);

    // Restart from DONE; three words with byte_valid toggling
    $display("[TB] three word load, toggling valid");
    wr_base = wr_count;
    pulse_start();
    @(negedge clk);
    check_output("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check_output("restart_done", 32'(done), 32'd0);
    tick();
    send_byte(8'h03, 1);
    send_word(32'h1122_3344, 1, 6'd0);
    pulse_start();
    send_word(32'hAABB_CCDD, 1, 6'd1);
    send_word(32'hDEAD_BEEF, 1, 6'd2);
    @(negedge clk);
    check_output("w3_done", 32'(done), 32'd1);
    check_output("w3_hold_addr", 32'(mem_waddr), 32'd2);
    tick();
    check_output("w3_wr_count", 32'(wr_count - wr_base), 32'd3);

    // Zero-length program
    $display("[TB] zero header");
    wr_base = wr_count;
    pulse_start();
    send_byte(8'h00, 0);
    @(negedge clk);
    check_output("zero_done", 32'(done), 32'd1);
    check_output("zero_cpu_rst", 32'(cpu_rst), 32'd0);
    tick();
    check_output("zero_wr_count", 32'(wr_count - wr_base), 32'd0);

    // Oversized header then recovery
    $display("[TB] illegal header");
    wr_base = wr_count;
    pulse_start();
    send_byte(8'h41, 0);
    @(negedge clk);
    check_output("err_err", 32'(err), 32'd1);
    check_output("err_cpu_rst", 32'(cpu_rst), 32'd1);
    check_output("err_done", 32'(done), 32'd0);
    check_output("err_ready", 32'(byte_ready), 32'd0);
    tick();
    byte_valid = 1'b1;
    byte_data  = 8'h5C;
    repeat (4) tick();
    byte_valid = 1'b0;
    check_output("err_wr_count", 32'(wr_count - wr_base), 32'd0);
    pulse_start();
    @(negedge clk);
    check_output("err_cleared", 32'(err), 32'd0);
    check_output("err_hdr_ready", 32'(byte_ready), 32'd1);
    tick();
    send_byte(8'h01, 0);
    send_word(32'h1234_5678, 0, 6'd0);
    @(negedge clk);
    check_output("recover_done", 32'(done), 32'd1);
    check_output("recover_err", 32'(err), 32'd0);
    tick();

    // Reset in the middle of word 1
    $display("[TB] reset mid-load");
    pulse_start();
    send_byte(8'h02, 0);
    send_word(32'h0BAD_F00D, 0, 6'd0);
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    wr_base    = wr_count;
    rst        = 1'b1;
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    @(negedge clk);
    check_output("midrst_cycle_ready", 32'(byte_ready), 32'd0);
    check_output("midrst_cycle_we", 32'(mem_we), 32'd0);
    tick();
    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    check_output("midrst_ready", 32'(byte_ready), 32'd0);
    check_output("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_output("midrst_done", 32'(done), 32'd0);
    check_output("midrst_addr", 32'(mem_waddr), 32'd0);
    check_output("midrst_data", mem_wdata, 32'd0);
    tick();
    repeat (3) tick();
    check_output("midrst_wr_count", 32'(wr_count - wr_base), 32'd0);
    pulse_start();
    send_byte(8'h01, 0);
    send_word(32'hCAFE_F00D, 0, 6'd0);
    @(negedge clk);
    check_output("after_rst_done", 32'(done), 32'd1);
    tick();

    // Full-depth load
    $display("[TB] full depth load");
    wr_base = wr_count;
    pulse_start();
    send_byte(8'h40, 0);
    for (int i = 0; i < 64; i++) send_word(big_word(i), 0, 6'(i));
    @(negedge clk);
    check_output("full_done", 32'(done), 32'd1);
    check_output("full_cpu_rst", 32'(cpu_rst), 32'd0);
    check_output("full_last_addr", 32'(mem_waddr), 32'd63);
    check_output("full_last_data", mem_wdata, big_word(63));
    tick();
    repeat (3) tick();
    check_output("full_wr_count", 32'(wr_count - wr_base), 32'd64);
    check_output("full_hold_addr", 32'(mem_waddr), 32'd63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
